// File: rtl/signed_sort4_ctrl.sv
// Sequential 4-element signed bubble sorter sharing a single greater-than compare per cycle.
// Optional macro SIGNED_SORT_EARLY_EXIT_EN: finish at the end of the first pass that makes no swaps.
module signed_sort4_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*WIDTH-1:0]   in_data,
    output logic                 busy,
    output logic                 done,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [2:0]           swap_count
);

    localparam int unsigned N = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                  state, state_n;
    logic signed [WIDTH-1:0] e   [N];
    logic signed [WIDTH-1:0] e_n [N];
    logic [1:0]              pass, pass_n;
    logic [1:0]              j, j_n;
    logic                    swapped, swapped_n;
    logic [2:0]              swap_count_n;
    logic                    busy_n, done_n;

    logic [1:0]              j_p1;
    logic signed [WIDTH-1:0] op_a, op_b;
    logic                    gt;
    logic                    last_in_pass;
    logic                    last_step;
    logic                    finish;

    // Shared comparator and schedule position decode
    always_comb begin
        j_p1         = 2'(j + 2'd1);
        op_a         = e[j];
        op_b         = e[j_p1];
        gt           = op_a > op_b;
        last_in_pass = (j == 2'(2'd2 - pass));
        last_step    = last_in_pass && (pass == 2'd2);
`ifdef SIGNED_SORT_EARLY_EXIT_EN
        finish       = last_in_pass && (last_step || !(swapped || gt));
`else
        finish       = last_step;
`endif
    end

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_n      = state;
        for (int i = 0; i < N; i++) begin
            e_n[i] = e[i];
        end
        pass_n       = pass;
        j_n          = j;
        swapped_n    = swapped;
        swap_count_n = swap_count;
        busy_n       = 1'b0;
        done_n       = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    for (int i = 0; i < N; i++) begin
                        e_n[i] = in_data[i*WIDTH +: WIDTH];
                    end
                    swap_count_n = 3'd0;
                    swapped_n    = 1'b0;
                    pass_n       = 2'd0;
                    j_n          = 2'd0;
                    busy_n       = 1'b1;
                    state_n      = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (gt) begin
                    e_n[j]       = op_b;
                    e_n[j_p1]    = op_a;
                    swap_count_n = 3'(swap_count + 3'd1);
                    swapped_n    = 1'b1;
                end
                if (finish) begin
                    done_n  = 1'b1;
                    state_n = S_DONE;
                end else if (last_in_pass) begin
                    pass_n    = 2'(pass + 2'd1);
                    j_n       = 2'd0;
                    swapped_n = 1'b0;
                    busy_n    = 1'b1;
                end else begin
                    j_n    = j_p1;
                    busy_n = 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            for (int i = 0; i < N; i++) begin
                e[i] <= '0;
            end
            pass       <= 2'd0;
            j          <= 2'd0;
            swapped    <= 1'b0;
            swap_count <= 3'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            for (int i = 0; i < N; i++) begin
                e[i] <= e_n[i];
            end
            pass       <= pass_n;
            j          <= j_n;
            swapped    <= swapped_n;
            swap_count <= swap_count_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign out_data[g*WIDTH +: WIDTH] = e[g];
    end

endmodule

// File: tb/tb_signed_sort4_ctrl.sv
// Scoreboard bench for signed_sort4_ctrl; expected results come from an inversion-count reference model.
module tb_signed_sort4_ctrl;

    localparam int unsigned W = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [4*W-1:0] in_data;
    logic           busy;
    logic           done;
    logic [4*W-1:0] out_data;
    logic [2:0]     swap_count;

    signed_sort4_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_data    (in_data),
        .busy       (busy),
        .done       (done),
        .out_data   (out_data),
        .swap_count (swap_count)
    );

    typedef struct {
        logic [4*W-1:0] data;
        int             swaps;
        int             lat;
        time            t_acc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [4*W-1:0] pk(input int a0, input int a1, input int a2, input int a3);
        logic [4*W-1:0] r;
        r[0*W +: W] = W'(a0);
        r[1*W +: W] = W'(a1);
        r[2*W +: W] = W'(a2);
        r[3*W +: W] = W'(a3);
        return r;
    endfunction

    // Reference: sorted values, swaps = inversion count, passes needed = max larger-left count
    function automatic exp_t model(input logic [4*W-1:0] d);
        exp_t                x;
        int                  v[4];
        int                  inv;
        int                  k;
        int                  cnt;
        int                  tmp;
        int                  steps;
        logic signed [W-1:0] t;
        for (int i = 0; i < 4; i++) begin
            t    = d[i*W +: W];
            v[i] = int'(t);
        end
        inv = 0;
        k   = 0;
        for (int b = 0; b < 4; b++) begin
            cnt = 0;
            for (int a = 0; a < b; a++) begin
                if (v[a] > v[b]) cnt++;
            end
            inv += cnt;
            if (cnt > k) k = cnt;
        end
        for (int a = 1; a < 4; a++) begin
            for (int b = a; b > 0 && v[b-1] > v[b]; b--) begin
                tmp    = v[b];
                v[b]   = v[b-1];
                v[b-1] = tmp;
            end
        end
        for (int i = 0; i < 4; i++) x.data[i*W +: W] = W'(v[i]);
        x.swaps = inv;
`ifdef SIGNED_SORT_EARLY_EXIT_EN
        steps = (k == 0) ? 3 : ((k == 1) ? 5 : 6);
`else
        steps = 6;
`endif
        x.lat   = steps + 1;
        x.t_acc = 0;
        return x;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding sort
    always @(negedge clk) begin
        exp_t x;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 32'(0));
            end else begin
                x = sb.pop_front();
                check("out_data", 32'(out_data), 32'(x.data));
                check("swap_count", 32'(swap_count), 32'(x.swaps));
                check("latency", 32'(int'(($time - x.t_acc) / 10) + 1), 32'(x.lat));
                check("busy_in_done", 32'(busy), 32'(0));
            end
        end
    end

    task automatic run_sort(input logic [4*W-1:0] d, input bit junk_start, input bit hold_start);
        exp_t x;
        int   budget;
        @(negedge clk);
        start   = 1'b1;
        in_data = d;
        @(posedge clk);
        x       = model(d);
        x.t_acc = $time;
        sb.push_back(x);
        @(negedge clk);
        start   = hold_start;
        in_data = 16'($urandom);
        check("busy_after_start", 32'(busy), 32'(1));
        if (junk_start) begin
            @(negedge clk);
            start   = 1'b1;
            in_data = 16'($urandom);
            @(negedge clk);
            start   = hold_start;
        end
        budget = 0;
        while (sb.size() != 0 && budget < 12) begin
            @(posedge clk);
            budget++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 32'(sb.size()), 32'(0));
            sb.delete();
        end
        #1;
        start = 1'b0;
        @(negedge clk);
        check("idle_after_done", 32'(busy | done), 32'(0));
        check("out_stable", 32'(out_data), 32'(x.data));
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_out", 32'(out_data), 32'(0));
        check("reset_swaps", 32'(swap_count), 32'(0));
        rst = 1'b0;

        run_sort(pk(5, 3, -1, -4), 1'b0, 1'b0);
        run_sort(pk(-8, -1, 0, 7), 1'b0, 1'b0);
        run_sort(pk(7, -8, 7, -8), 1'b0, 1'b0);
        run_sort(pk(-7, 2, -7, 2), 1'b0, 1'b0);
        run_sort(pk(5, 3, -1, -4), 1'b1, 1'b0);
        run_sort(pk(-8, -1, 0, 7), 1'b0, 1'b1);

        // Reset during the third compare cycle, then a fresh sort
        @(negedge clk);
        start   = 1'b1;
        in_data = pk(5, 3, -1, -4);
        @(negedge clk);
        start   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        check("midrst_out", 32'(out_data), 32'(0));
        check("midrst_swaps", 32'(swap_count), 32'(0));
        rst = 1'b0;
        run_sort(pk(1, 0, 0, 0), 1'b0, 1'b0);
        check("post_rst_sorted", 32'(out_data), 32'(pk(0, 0, 0, 1)));

        for (int n = 0; n < 40; n++) begin
            run_sort(16'($urandom), 1'($urandom), 1'($urandom));
        end

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/signed_sort4_ctrl.md
# signed_sort4_ctrl

Sequential controller that sorts four signed WIDTH-bit operands into ascending order using a single shared signed greater-than comparison per clock, in bubble-sort order. It sits in front of the combinational signed comparator stage. It sequences operand pairs through that one compare, swaps the register file on each "greater" result, and signals completion with a one-cycle done pulse.

## Interface
- WIDTH, 4, bit width of each signed element (two's complement)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request to sort; sampled only in IDLE
- in_data  input  4*WIDTH  four signed elements; element i at bits [i*WIDTH +: WIDTH]
- busy  output  1  high while compare steps are in progress
- done  output  1  one-cycle pulse when out_data holds the sorted result
- out_data  output  4*WIDTH  sorted elements; element 0 is the smallest, same packing as in_data
- swap_count  output  3  number of swaps performed in the current or last sort (0..6)

## Operation
- States:
  - IDLE: accepts start.
  - COMPARE: one compare step per cycle.
  - DONE: single cycle, then back to IDLE.
- IDLE with start=1 at a clock edge:
  - latch in_data into the four-element register file
  - clear swap_count and the pass swap flag
  - set pass=0, j=0, and enter COMPARE
- Compare schedule (pass, j), in order:
  - pass 0: (0,0), (0,1), (0,2)
  - pass 1: (1,0), (1,1)
  - pass 2: (2,0)
  - Six steps in total.
- Each COMPARE cycle:
  - evaluate e[j] > e[j+1] as a signed comparison
  - if true: swap e[j] and e[j+1], increment swap_count, set the pass swap flag
  - equal elements are never swapped, so the sort is stable
- Last step (2,0) completes → DONE. DONE asserts done for one cycle → IDLE.
- start is ignored in COMPARE and DONE; a start held high in DONE is not captured. The requester re-asserts start in IDLE.
- in_data is sampled only on the accepting edge; later changes have no effect.
- out_data continuously reflects the register file:
  - it changes during COMPARE
  - it is stable and valid from the done cycle until the next accepted start
- Reset (rst=1 at any edge, including mid-sort):
  - state goes to IDLE
  - register file, out_data and swap_count go to 0
  - busy=0, done=0
  - rst overrides a simultaneous start

## Timing
- Start accepted at edge E0. busy=1 in the cycles after E0 through E6.
- Compare steps are performed at edges E1..E6.
- done=1 for exactly the cycle after E6, i.e. 7 cycles after start accepted. busy=0 in that cycle.
- Next start can be accepted at edge E8 at the earliest: the cycle after done returns to IDLE.
- Reset values of outputs: busy=0, done=0, out_data=0, swap_count=0.
- No combinational path from inputs to outputs.

## Configuration
- SIGNED_SORT_EARLY_EXIT_EN defined:
  - at the last step of a pass, if that pass performed zero swaps (including a swap on this step), go directly to DONE
  - already-sorted input finishes after pass 0: 3 compare steps, done 4 cycles after start
- Undefined: all 6 steps always run; latency is fixed at done 7 cycles after start.
- Sorted result and swap_count are identical in both builds.

## Test plan
- Unsorted input: in_data elements {5,3,-1,-4} → out_data {-4,-1,3,5}, swap_count=6, done exactly 7 cycles after start (both builds).
- Already sorted: {-8,-1,0,7} → out_data unchanged, swap_count=0; done at 7 cycles without the macro, 4 cycles with SIGNED_SORT_EARLY_EXIT_EN.
- Signed extremes: {7,-8,7,-8} → {-8,-8,7,7}, swap_count=3, which checks signed rather than unsigned ordering.
- Duplicates and stability: {-7,2,-7,2} → {-7,-7,2,2}, swap_count=1; with the macro, done 6 cycles after start (pass 1 has no swaps).
- Reset mid-sort: assert rst during the 3rd compare cycle → next edge busy=0, done=0, out_data=0, swap_count=0. A subsequent start with {1,0,0,0} → {0,0,0,1}.
- Start ignored:
  - pulse start during busy with different in_data → result and timing of the original sort unchanged
  - start held high in the done cycle → no new sort until IDLE
